regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined CPU's decode stage, generalising the fixed 32×64-bit read multiplexor into a complete storage block. It holds DEPTH words of WIDTH bits and provides NUM_RD independent read ports plus one write port. It adds write-to-read bypass, a hardwired zero register, and an optional registered read path with a per-port request/valid handshake. It replaces the separate register array and read-mux instances in decode.

---
 rtl/regfile_mp.sv | 92 +++++++++
 tb/tb_regfile_mp.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage: one write port, NUM_RD read ports,
// write-to-read bypass, optional hardwired zero register and optional registered reads.
module regfile_mp #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned ZERO_EN = 1,
  parameter int unsigned REG_OUT = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [NUM_RD-1:0]              rd_req,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ZERO_X  = (ADDR_W+1)'(DEPTH - 1);

  logic [WIDTH-1:0]             mem [DEPTH];
  logic [NUM_RD-1:0][WIDTH-1:0] rd_val;
  logic                         wr_ok;

  // Out-of-range addresses are inert; they never alias modulo DEPTH.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_EN != 0) && ({1'b0, a} == ZERO_X);
  endfunction

  // Only a legal write updates storage or feeds the bypass.
  assign wr_ok = wr_en && in_range(wr_addr) && !is_zero(wr_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Per-port priority: out-of-range, zero register, bypass, storage.
  always_comb begin
    rd_val = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (!in_range(rd_addr[p]) || is_zero(rd_addr[p])) begin
        rd_val[p] = '0;
      end else if (wr_ok && (wr_addr == rd_addr[p])) begin
        rd_val[p] = wr_data;
      end else begin
        rd_val[p] = mem[rd_addr[p]];
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic [NUM_RD-1:0][WIDTH-1:0] rd_q;
    logic [NUM_RD-1:0]            vld_q;

    // Data holds when not requested; valid marks the cycle after a request.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q  <= '0;
        vld_q <= '0;
      end else begin
        for (int unsigned p = 0; p < NUM_RD; p++) begin
          vld_q[p] <= rd_req[p];
          if (rd_req[p]) begin
            rd_q[p] <= rd_val[p];
          end
        end
      end
    end

    assign rd_data  = rd_q;
    assign rd_valid = vld_q;
  end else begin : g_comb
    logic unused_req;

    assign unused_req = ^rd_req;
    assign rd_data    = rd_val;
    assign rd_valid   = '1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: three regfile_mp configurations share one stimulus stream
// (combinational default, DEPTH=24 registered, ZERO_EN=0 combinational).
module tb_regfile_mp;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                  clk;
  logic                  reset;
  logic                  wr_en;
  logic [4:0]            wr_addr;
  logic [63:0]           wr_data;
  logic [1:0]            rd_req;
  logic [1:0][4:0]       rd_addr;
  logic [1:0][63:0]      d0, d1, d2;
  logic [1:0]            v0, v1, v2;

  int tests  = 0;
  int failed = 0;

  regfile_mp u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0)
  );

  regfile_mp #(.DEPTH(24), .REG_OUT(1)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1)
  );

  regfile_mp #(.ZERO_EN(0)) u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(d2), .rd_valid(v2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [1:0]  req;
    logic [4:0]  a0, a1;
    logic [63:0] e0a, e0b;  // u0, same cycle
    logic [63:0] e2a, e2b;  // u2, same cycle
    logic [63:0] e1a, e1b;  // u1, after the edge
    logic [1:0]  ev1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                     input logic [1:0] req, input logic [4:0] a0, input logic [4:0] a1,
                     input logic [63:0] e0a, input logic [63:0] e0b,
                     input logic [63:0] e2a, input logic [63:0] e2b,
                     input logic [63:0] e1a, input logic [63:0] e1b,
                     input logic [1:0] ev1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.req = req; v.a0 = a0; v.a1 = a1;
    v.e0a = e0a; v.e0b = e0b; v.e2a = e2a; v.e2b = e2b;
    v.e1a = e1a; v.e1b = e1b; v.ev1 = ev1;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [1:0] req, input logic [4:0] a0, input logic [4:0] a1);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_req = req;
    rd_addr[0] = a0; rd_addr[1] = a1;
  endtask

  initial begin
    //   we  wa  wd                req    a0  a1   u0 p0/p1          u2 p0/p1          u1 p0/p1          u1 vld
    add(1, 3,  64'h1234,       2'b11, 3,  30, 64'h1234, 0,        64'h1234, 0,        64'h1234, 0,        2'b11);
    add(1, 30, ONES,           2'b11, 3,  30, 64'h1234, ONES,     64'h1234, ONES,     64'h1234, 0,        2'b11);
    add(0, 0,  0,              2'b11, 3,  30, 64'h1234, ONES,     64'h1234, ONES,     64'h1234, 0,        2'b11);
    add(1, 7,  64'hABCD,       2'b11, 7,  7,  64'hABCD, 64'hABCD, 64'hABCD, 64'hABCD, 64'hABCD, 64'hABCD, 2'b11);
    add(1, 31, 64'h55,         2'b11, 31, 31, 0,        0,        64'h55,   64'h55,   0,        0,        2'b11);
    add(0, 0,  0,              2'b11, 31, 7,  0,        64'hABCD, 64'h55,   64'hABCD, 0,        64'hABCD, 2'b11);
    add(1, 26, 64'h99,         2'b11, 26, 2,  64'h99,   0,        64'h99,   0,        0,        0,        2'b11);
    add(0, 0,  0,              2'b11, 26, 2,  64'h99,   0,        64'h99,   0,        0,        0,        2'b11);
    add(1, 23, 64'h77,         2'b11, 23, 23, 64'h77,   64'h77,   64'h77,   64'h77,   0,        0,        2'b11);
    add(0, 0,  0,              2'b11, 23, 3,  64'h77,   64'h1234, 64'h77,   64'h1234, 0,        64'h1234, 2'b11);
    add(0, 0,  0,              2'b01, 3,  3,  64'h1234, 64'h1234, 64'h1234, 64'h1234, 64'h1234, 64'h1234, 2'b01);
    add(1, 3,  64'h42,         2'b00, 3,  3,  64'h42,   64'h42,   64'h42,   64'h42,   64'h1234, 64'h1234, 2'b00);
    add(0, 0,  0,              2'b01, 3,  3,  64'h42,   64'h42,   64'h42,   64'h42,   64'h42,   64'h1234, 2'b01);

    reset = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0);
    #12;
    chk("rst_u0_data", 0, d0[0] | d0[1], 64'h0);
    chk("rst_u0_valid", 0, 64'(v0), 64'h3);
    chk("rst_u1_valid", 0, 64'(v1), 64'h0);
    chk("rst_u1_data", 0, d1[0] | d1[1], 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].req, vecs[i].a0, vecs[i].a1);
      #1;
      chk("u0_p0", i, d0[0], vecs[i].e0a);
      chk("u0_p1", i, d0[1], vecs[i].e0b);
      chk("u2_p0", i, d2[0], vecs[i].e2a);
      chk("u2_p1", i, d2[1], vecs[i].e2b);
      @(posedge clk);
      #1;
      chk("u1_p0", i, d1[0], vecs[i].e1a);
      chk("u1_p1", i, d1[1], vecs[i].e1b);
      chk("u1_valid", i, 64'(v1), 64'(vecs[i].ev1));
    end

    // Reset mid-run: write r5, read it back, then reset between edges.
    @(negedge clk);
    drive(1, 5, 64'hDEAD_BEEF, 2'b11, 5, 5);
    @(negedge clk);
    drive(0, 0, 0, 2'b11, 5, 5);
    #1;
    chk("pre_rst_u0", 0, d0[0], 64'hDEAD_BEEF);
    @(posedge clk);
    #1;
    chk("pre_rst_u1", 0, d1[1], 64'hDEAD_BEEF);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_u0", 0, d0[0], 64'h0);
    chk("mid_rst_u2", 0, d2[1], 64'h0);
    chk("mid_rst_u1", 0, d1[0] | d1[1], 64'h0);
    chk("mid_rst_u1_valid", 0, 64'(v1), 64'h0);
    chk("mid_rst_u0_valid", 0, 64'(v0), 64'h3);
    // A write pending across the reset edge must be dropped.
    drive(1, 5, 64'h1111, 2'b11, 5, 5);
    @(posedge clk);
    #1;
    chk("in_rst_u1_valid", 0, 64'(v1), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 2'b11, 5, 5);
    #1;
    chk("post_rst_u0", 0, d0[0], 64'h0);
    @(posedge clk);
    #1;
    chk("post_rst_u1", 0, d1[0], 64'h0);
    chk("post_rst_u1_valid", 0, 64'(v1), 64'h3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
